// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one single-cycle integer ALU between the main execute path (requester 0)
// and the branch/address-compare path (requester 1). Requests are arbitrated
// round-robin and the winner's operands are registered onto the ALU bus. The
// execute phase is held for MUL_CYCLES on multiply and one cycle otherwise. The
// captured result and flags are then returned on the owner's response channel.
// Only one operation is in flight at a time.

module alu_share_arbiter #(
  parameter int DATA_W     = 32,
  parameter int OP_W       = 4,
  parameter int MUL_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,

  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_blt,
  input  logic              alu_bgt,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [2:0]        rsp_flags,

  output logic              busy
);

  // The counter holds "remaining execute cycles minus one". A 4-bit counter
  // covers the legal MUL_CYCLES range of 1..15.
  localparam int                CNT_W    = 4;
  localparam logic [OP_W-1:0]   OP_MUL   = OP_W'(4'b1100);
  localparam logic [CNT_W-1:0]  MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;

  logic                prio_r;
  logic                owner_r;
  logic [CNT_W-1:0]    cnt_r;

  logic [DATA_W-1:0]   alu_a_r;
  logic [DATA_W-1:0]   alu_b_r;
  logic [OP_W-1:0]     alu_op_r;
  logic [DATA_W-1:0]   rsp_result_r;
  logic [2:0]          rsp_flags_r;

  logic                grant_vld_s;
  logic                grant_idx_s;
  logic                hs_s;
  logic                exec_done_s;
  logic                owner_rdy_s;
  logic [DATA_W-1:0]   sel_a_s;
  logic [DATA_W-1:0]   sel_b_s;
  logic [OP_W-1:0]     sel_op_s;
  logic [CNT_W-1:0]    cnt_load_s;

  // Round-robin grant: a lone requester wins outright, a tie goes to prio_r.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_vld_s = 1'b1;
      grant_idx_s = prio_r;
    end else if (req0_valid) begin
      grant_vld_s = 1'b1;
      grant_idx_s = 1'b0;
    end else if (req1_valid) begin
      grant_vld_s = 1'b1;
      grant_idx_s = 1'b1;
    end else begin
      grant_vld_s = 1'b0;
      grant_idx_s = 1'b0;
    end
  end

  // Operand and opcode mux from the granted requester, plus the exec counter load value.
  always_comb begin
    sel_a_s    = req0_a;
    sel_b_s    = req0_b;
    sel_op_s   = req0_op;
    cnt_load_s = CNT_ZERO;
    if (grant_idx_s) begin
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
      sel_op_s = req1_op;
    end else begin
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
      sel_op_s = req0_op;
    end
    if (sel_op_s == OP_MUL) begin
      cnt_load_s = MUL_LOAD;
    end else begin
      cnt_load_s = CNT_ZERO;
    end
  end

  // Handshake only in IDLE, and never while reset is asserted, so ready stays low in reset.
  assign hs_s        = rst_n && (state_r == IDLE) && grant_vld_s;
  assign exec_done_s = (state_r == EXEC) && (cnt_r == CNT_ZERO);
  assign owner_rdy_s = owner_r ? rsp1_ready : rsp0_ready;

  // Next-state logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_s) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        if (exec_done_s) begin
          state_s = RESP;
        end else begin
          state_s = EXEC;
        end
      end
      RESP: begin
        if (owner_rdy_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Owner and round-robin priority update on each accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r <= 1'b0;
      prio_r  <= 1'b0;
    end else if (hs_s) begin
      owner_r <= grant_idx_s;
      prio_r  <= ~grant_idx_s;
    end else begin
      owner_r <= owner_r;
      prio_r  <= prio_r;
    end
  end

  // Execute-cycle counter: loaded on accept, counts down to zero during EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
    end else if (hs_s) begin
      cnt_r <= cnt_load_s;
    end else if ((state_r == EXEC) && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // ALU input bus: captured on accept and held until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_r  <= {DATA_W{1'b0}};
      alu_b_r  <= {DATA_W{1'b0}};
      alu_op_r <= {OP_W{1'b0}};
    end else if (hs_s) begin
      alu_a_r  <= sel_a_s;
      alu_b_r  <= sel_b_s;
      alu_op_r <= sel_op_s;
    end else begin
      alu_a_r  <= alu_a_r;
      alu_b_r  <= alu_b_r;
      alu_op_r <= alu_op_r;
    end
  end

  // Response capture on the last execute cycle; held through RESP and beyond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_r <= {DATA_W{1'b0}};
      rsp_flags_r  <= 3'b000;
    end else if (exec_done_s) begin
      rsp_result_r <= alu_out;
      rsp_flags_r  <= {alu_zero, alu_blt, alu_bgt};
    end else begin
      rsp_result_r <= rsp_result_r;
      rsp_flags_r  <= rsp_flags_r;
    end
  end

  assign req0_ready = hs_s && !grant_idx_s;
  assign req1_ready = hs_s &&  grant_idx_s;

  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_op     = alu_op_r;
  assign rsp_result = rsp_result_r;
  assign rsp_flags  = rsp_flags_r;

  assign rsp0_valid = (state_r == RESP) && !owner_r;
  assign rsp1_valid = (state_r == RESP) &&  owner_r;
  assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level reference model.

module tb_alu_share_arbiter;

  localparam int DW  = 32;
  localparam int OW  = 4;
  localparam int MUL = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OW-1:0] req0_op, req1_op;
  logic [DW-1:0] alu_a, alu_b, alu_out;
  logic [OW-1:0] alu_op;
  logic          alu_zero, alu_blt, alu_bgt;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DW-1:0] rsp_result;
  logic [2:0]    rsp_flags;
  logic          busy;

  alu_share_arbiter #(.DATA_W(DW), .OP_W(OW), .MUL_CYCLES(MUL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .alu_zero(alu_zero), .alu_blt(alu_blt), .alu_bgt(alu_bgt),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {zero, blt, bgt, result}.
  function automatic logic [34:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic z, lt, ge;
    r = 32'd0; z = 1'b0; lt = 1'b0; ge = 1'b0;
    case (op)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b1000: begin r = a - b; z = (a == b); lt = ($signed(a) < $signed(b)); ge = !lt; end
      4'b1001: begin r = a - b; z = (a == b); lt = (a < b); ge = !lt; end
      4'b1100: r = a * b;
      default: r = 32'd0;
    endcase
    return {z, lt, ge, r};
  endfunction

  logic [34:0] alu_v;
  always_comb begin
    alu_v = alu_fn(alu_op, alu_a, alu_b);
  end
  assign alu_out  = alu_v[31:0];
  assign alu_bgt  = alu_v[32];
  assign alu_blt  = alu_v[33];
  assign alu_zero = alu_v[34];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_rsp = 0;

  // Reference model: transaction level (busy window, response cycle, priority bit).
  bit          m_active, m_owner, m_prio;
  int          m_rsp_from;
  logic [31:0] m_alu_a, m_alu_b, m_exp_res, m_shown_res;
  logic [3:0]  m_alu_op;
  logic [2:0]  m_exp_flags, m_shown_flags;

  // Observations of the DUT for directed checks.
  int          hs_cyc, last_lat, n_mul_cyc;
  bit          seen_valid = 1'b1;
  bit          last_owner;
  logic [31:0] last_res, res0, res1;
  logic [2:0]  last_flags;
  int          dut_grants[$];
  bit          auto_drop0 = 1'b1, auto_drop1 = 1'b1;

  logic [3:0]  op_tab [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                               4'b1000, 4'b1001, 4'b1100, 4'b1101, 4'b1111};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: entered just after a negedge with inputs already driven.
  task automatic step();
    int g;
    bit d0, d1;
    logic [31:0] ga, gb;
    logic [3:0]  gop;
    g = -1; d0 = 1'b0; d1 = 1'b0; ga = 32'd0; gb = 32'd0; gop = 4'd0;
    #1;
    if (m_active && cyc == m_rsp_from) begin
      m_shown_res   = m_exp_res;
      m_shown_flags = m_exp_flags;
    end
    if (!m_active) begin
      if (req0_valid && req1_valid) g = m_prio ? 1 : 0;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
    end
    chk("req0_ready", req0_ready, g == 0);
    chk("req1_ready", req1_ready, g == 1);
    chk("busy", busy, m_active);
    chk("rsp0_valid", rsp0_valid, m_active && cyc >= m_rsp_from && !m_owner);
    chk("rsp1_valid", rsp1_valid, m_active && cyc >= m_rsp_from && m_owner);
    chk("rsp_result", rsp_result, m_shown_res);
    chk("rsp_flags", rsp_flags, m_shown_flags);
    chk("alu_a", alu_a, m_alu_a);
    chk("alu_b", alu_b, m_alu_b);
    chk("alu_op", alu_op, m_alu_op);
    if (req0_valid && req0_ready) begin hs_cyc = cyc; seen_valid = 1'b0; dut_grants.push_back(0); end
    if (req1_valid && req1_ready) begin hs_cyc = cyc; seen_valid = 1'b0; dut_grants.push_back(1); end
    if ((rsp0_valid || rsp1_valid) && !seen_valid) begin
      seen_valid = 1'b1; last_lat = cyc - hs_cyc; last_owner = rsp1_valid;
    end
    if (busy && !rsp0_valid && !rsp1_valid && alu_op == 4'b1100) n_mul_cyc++;
    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
      last_res = rsp_result; last_flags = rsp_flags; n_rsp++;
      if (rsp0_valid) res0 = rsp_result; else res1 = rsp_result;
    end
    if (g == 0) begin ga = req0_a; gb = req0_b; gop = req0_op; d0 = auto_drop0; end
    if (g == 1) begin ga = req1_a; gb = req1_b; gop = req1_op; d1 = auto_drop1; end
    if (g >= 0) begin
      m_active   = 1'b1;
      m_owner    = (g == 1);
      m_prio     = (g == 0);
      m_rsp_from = cyc + ((gop == 4'b1100) ? (1 + MUL) : 2);
      {m_exp_flags, m_exp_res} = alu_fn(gop, ga, gb);
      m_alu_a = ga; m_alu_b = gb; m_alu_op = gop;
    end else if (m_active && cyc >= m_rsp_from && (m_owner ? rsp1_ready : rsp0_ready)) begin
      m_active = 1'b0;
    end
    @(negedge clk);
    cyc++;
    if (d0) req0_valid = 1'b0;
    if (d1) req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", alu_op, 4'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_flags", rsp_flags, 3'd0);
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    chk("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    m_active = 1'b0; m_prio = 1'b0; m_owner = 1'b0;
    m_alu_a = 32'd0; m_alu_b = 32'd0; m_alu_op = 4'd0;
    m_shown_res = 32'd0; m_shown_flags = 3'd0;
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
  endtask

  task automatic run_rsp(input int want, input int budget, input string tag);
    int start;
    start = n_rsp;
    for (int i = 0; i < budget && n_rsp < start + want; i++) step();
    chk(tag, n_rsp - start, want);
  endtask

  task automatic do_op0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input string tag);
    req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    run_rsp(1, 20, tag);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'd0; req0_b = 32'd0; req0_op = 4'd0;
    req1_a = 32'd0; req1_b = 32'd0; req1_op = 4'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Single non-multiply request on requester 0.
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    do_op0(32'd5, 32'd7, 4'b0000, "single_done");
    chk("single_result", last_res, 32'd12);
    chk("single_latency", last_lat, 2);
    chk("single_owner", last_owner, 1'b0);

    // Round-robin with both requesters held valid.
    do_reset();
    auto_drop0 = 1'b0; auto_drop1 = 1'b0;
    req0_a = 32'd10; req0_b = 32'd3; req0_op = 4'b0001; req0_valid = 1'b1;
    req1_a = 32'hF0; req1_b = 32'hFF; req1_op = 4'b0100; req1_valid = 1'b1;
    dut_grants.delete();
    run_rsp(8, 60, "rr_done");
    req0_valid = 1'b0; req1_valid = 1'b0;
    auto_drop0 = 1'b1; auto_drop1 = 1'b1;
    chk("rr_count", dut_grants.size(), 8);
    for (int i = 0; i < dut_grants.size(); i++) chk("rr_order", dut_grants[i], i % 2);
    chk("rr_res0", res0, 32'd7);
    chk("rr_res1", res1, 32'h0F);

    // Multiply latency on requester 1.
    n_mul_cyc = 0;
    req1_a = 32'd3; req1_b = 32'd4; req1_op = 4'b1100; req1_valid = 1'b1;
    run_rsp(1, 20, "mul_done");
    chk("mul_result", last_res, 32'd12);
    chk("mul_latency", last_lat, 1 + MUL);
    chk("mul_owner", last_owner, 1'b1);
    chk("mul_op_cycles", n_mul_cyc, MUL);

    // Backpressure on requester 0 while requester 1 waits.
    rsp0_ready = 1'b0;
    req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'b0000; req0_valid = 1'b1;
    req1_a = 32'd3; req1_b = 32'd5; req1_op = 4'b0100; req1_valid = 1'b1;
    for (int i = 0; i < 10 && !rsp0_valid; i++) step();
    chk("bp_valid_reached", rsp0_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", rsp0_valid, 1'b1);
      chk("bp_hold_result", rsp_result, 32'd2);
      chk("bp_hold_busy", busy, 1'b1);
      chk("bp_req1_wait", req1_ready, 1'b0);
    end
    rsp0_ready = 1'b1;
    step();
    #1;
    chk("bp_req1_next", req1_ready, 1'b1);
    run_rsp(1, 20, "bp_req1_done");
    chk("bp_req1_result", res1, 32'd6);

    // Branch flags.
    do_op0(32'hFFFF_FFFF, 32'd1, 4'b1000, "flag_slt_done");
    chk("flag_slt", last_flags, 3'b010);
    do_op0(32'hFFFF_FFFF, 32'd1, 4'b1001, "flag_uge_done");
    chk("flag_uge", last_flags, 3'b001);
    do_op0(32'd9, 32'd9, 4'b1000, "flag_eq_done");
    chk("flag_eq", last_flags, 3'b101);
    do_op0(32'd9, 32'd4, 4'b1110, "illegal_op_done");
    chk("illegal_op_result", last_res, 32'd0);

    // Reset in the middle of a multiply.
    req0_a = 32'd6; req0_b = 32'd7; req0_op = 4'b1100; req0_valid = 1'b1;
    step();
    step();
    chk("midrst_inflight", busy, 1'b1);
    req1_a = 32'd8; req1_b = 32'd2; req1_op = 4'b0001; req1_valid = 1'b1;
    do_reset();
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    req0_a = 32'd20; req0_b = 32'd22; req0_op = 4'b0000; req0_valid = 1'b1;
    req1_valid = 1'b1;
    dut_grants.delete();
    run_rsp(2, 30, "midrst_after_done");
    chk("midrst_grant_count", dut_grants.size(), 2);
    if (dut_grants.size() > 0) chk("midrst_first_grant", dut_grants[0], 0);
    chk("midrst_res0", res0, 32'd42);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_op = op_tab[$urandom_range(0, 9)];
        req0_a  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        req0_b  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        req0_valid = 1'b1;
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_op = op_tab[$urandom_range(0, 9)];
        req1_a  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        req1_b  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        req1_valid = 1'b1;
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 30 && m_active; i++) step();
    chk("drain_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1);
  end

endmodule
